// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell walks a WIDTH-bit operand pair
// LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q, ovf_q;

    logic             accept, last, s, c_next;
    logic [WIDTH:0]   res_ext;

    assign accept  = (state_q == StIdle) && start;
    assign last    = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));
    assign s       = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_next  = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
    assign res_ext = {s, res_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last)  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StRun) || (state_q == StDone);
        done = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= sub ? ~b_in : b_in;
            carry_q <= sub | cin;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            carry_q <= c_next;
            res_q   <= res_ext[WIDTH:1];
            cnt_q   <= cnt_q + CntW'(1);
            if (last) begin
                // carry_q here is the carry into the MSB
                sum_q  <= res_ext[WIDTH:1];
                cout_q <= c_next;
                ovf_q  <= carry_q ^ c_next;
            end
        end
    end

    assign sum_out = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and back-to-back checks for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, sub, cin;
    logic [7:0] a_in, b_in;
    logic       busy, done, cout, ovf;
    logic [7:0] sum_out;

    int n_checks = 0;
    int n_pass   = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub     (sub),
        .cin     (cin),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, cout, sum}
    function automatic logic [9:0] model(logic [7:0] a, logic [7:0] b, logic c, logic s);
        logic [8:0] t;
        logic       v;
        if (s) begin
            t = {1'b0, a} + {1'b0, ~b} + 9'd1;
            v = (a[7] != b[7]) && (t[7] != a[7]);
        end else begin
            t = {1'b0, a} + {1'b0, b} + {8'd0, c};
            v = (a[7] == b[7]) && (t[7] != a[7]);
        end
        return {v, t};
    endfunction

    // Drives one operation from IDLE; returns results, done latency (-1 on timeout)
    // and busy cycle count; leaves the DUT in IDLE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, output logic [7:0] res, output logic co,
                          output logic ov, output int lat, output int busy_cnt);
        start = 1'b1; a_in = a; b_in = b; cin = c; sub = s;
        tick();
        start = 1'b0;
        lat = -1; busy_cnt = 0; res = 'x; co = 1'bx; ov = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = k; res = sum_out; co = cout; ov = ovf;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
        tick(); tick();
        n_checks++;
        if ({busy, done, cout, ovf} !== 4'b0000)
            $display("FAIL reset_flags: got busy/done/cout/ovf=%b expected 0000",
                     {busy, done, cout, ovf});
        else n_pass++;
        n_checks++;
        if (sum_out !== 8'h00) $display("FAIL reset_sum: got %h expected 00", sum_out);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [7:0] va[3] = '{8'h5A, 8'hFF, 8'h00};
        logic [7:0] vb[3] = '{8'h3C, 8'h01, 8'h00};
        logic       vc[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] es[3] = '{8'h96, 8'h00, 8'h01};
        logic       eco[3] = '{1'b0, 1'b1, 1'b0};
        logic       eov[3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] r;
        logic       co, ov;
        int         lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b0, r, co, ov, lat, bc);
            n_checks++;
            if (lat != 9) $display("FAIL add%0d_latency: got %0d expected 9", i, lat);
            else n_pass++;
            n_checks++;
            if (r !== es[i]) $display("FAIL add%0d_sum: got %h expected %h", i, r, es[i]);
            else n_pass++;
            n_checks++;
            if ({co, ov} !== {eco[i], eov[i]})
                $display("FAIL add%0d_cout_ovf: got %b expected %b", i, {co, ov},
                         {eco[i], eov[i]});
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (bc != 9) $display("FAIL add_busy_cycles: got %0d expected 9", bc);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL add_idle_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_sub();
        // cin=1 on the first vector must be ignored for subtraction
        logic [7:0] va[3] = '{8'h05, 8'h10, 8'h80};
        logic [7:0] vb[3] = '{8'h03, 8'h20, 8'h01};
        logic       vc[3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] es[3] = '{8'h02, 8'hF0, 8'h7F};
        logic       eco[3] = '{1'b1, 1'b0, 1'b1};
        logic       eov[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] r;
        logic       co, ov;
        int         lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], 1'b1, r, co, ov, lat, bc);
            n_checks++;
            if (r !== es[i]) $display("FAIL sub%0d_sum: got %h expected %h", i, r, es[i]);
            else n_pass++;
            n_checks++;
            if ({co, ov} !== {eco[i], eov[i]})
                $display("FAIL sub%0d_cout_ovf: got %b expected %b", i, {co, ov},
                         {eco[i], eov[i]});
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        int         dones = 0;
        logic [7:0] r;
        logic       co, ov;
        int         lat, bc;
        start = 1'b1; a_in = 8'h77; b_in = 8'h11; cin = 1'b0; sub = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 1; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({busy, done, cout, ovf} !== 4'b0000)
            $display("FAIL abort_flags: got busy/done/cout/ovf=%b expected 0000",
                     {busy, done, cout, ovf});
        else n_pass++;
        n_checks++;
        if (sum_out !== 8'h00) $display("FAIL abort_sum: got %h expected 00", sum_out);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            if (done) dones++;
            tick();
        end
        n_checks++;
        if (dones != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        else n_pass++;
        run_op(8'h77, 8'h11, 1'b0, 1'b0, r, co, ov, lat, bc);
        n_checks++;
        if ({ov, co, r} !== {1'b1, 1'b0, 8'h88})
            $display("FAIL abort_rerun: got ovf/cout/sum=%b/%b/%h expected 1/0/88", ov, co, r);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int         dones = 0;
        int         done_at = -1;
        start = 1'b1; a_in = 8'h12; b_in = 8'h34; cin = 1'b0; sub = 1'b0;
        tick();
        for (int k = 1; k <= 15; k++) begin
            if (done) begin
                dones++;
                done_at = k;
            end
            start = (k == 3 || k == 8);
            a_in = 8'hFF; b_in = 8'hFF; sub = 1'b1; cin = 1'b1;
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (dones != 1) $display("FAIL ignore_done_count: got %0d expected 1", dones);
        else n_pass++;
        n_checks++;
        if (done_at != 9) $display("FAIL ignore_done_cycle: got %0d expected 9", done_at);
        else n_pass++;
        n_checks++;
        if ({cout, ovf, sum_out} !== {1'b0, 1'b0, 8'h46})
            $display("FAIL ignore_held_result: got cout/ovf/sum=%b/%b/%h expected 0/0/46",
                     cout, ovf, sum_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        int         cyc = 0;
        int         prev = -1;
        int         w;
        logic [7:0] na, nb;
        logic       nc, ns;
        na = 8'($urandom); nb = 8'($urandom); nc = 1'($urandom); ns = 1'($urandom);
        start = 1'b1; a_in = na; b_in = nb; cin = nc; sub = ns;
        exp = model(na, nb, nc, ns);
        for (int op = 0; op < 200; op++) begin
            w = 0;
            do begin
                tick();
                cyc++;
                w++;
            end while (!done && w < 30);
            n_checks++;
            if (!done) begin
                $display("FAIL b2b_timeout: op %0d got no done expected done", op);
                break;
            end
            n_pass++;
            n_checks++;
            if ({ovf, cout, sum_out} !== exp)
                $display("FAIL b2b_result: op %0d a=%h b=%h sub=%b got %b expected %b", op,
                         a_in, b_in, sub, {ovf, cout, sum_out}, exp);
            else n_pass++;
            if (prev >= 0) begin
                n_checks++;
                if (cyc - prev != 10)
                    $display("FAIL b2b_period: op %0d got %0d expected 10", op, cyc - prev);
                else n_pass++;
            end
            prev = cyc;
            na = 8'($urandom); nb = 8'($urandom); nc = 1'($urandom); ns = 1'($urandom);
            a_in = na; b_in = nb; cin = nc; sub = ns;
            exp = model(na, nb, nc, ns);
        end
        start = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_abort();
        test_ignore_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
